random_digit_gen: RTL and testbench

- Upstream feeder for the 7-segment digit decoders on the Display-Random board build.
- A push-button press starts a "dice roll": decimal digits cycle visibly for a fixed time, then settle on a pseudo-random result.
- Each 4-bit digit field drives one decoder instance directly and is always in the range 0-9.
- The LFSR runs continuously, so the result depends on when the button is pressed.

---
 rtl/random_digit_gen.sv | 109 ++++++++++
 tb/tb_random_digit_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/random_digit_gen.sv
// Dice-roll digit source for the 7-segment decoders: a button press cycles decimal
// digits for a fixed time, then holds a pseudo-random 0-9 result in each field.
module random_digit_gen #(
    parameter int unsigned NUM_DIGITS  = 2,
    parameter int unsigned STEP_CYCLES = 5_000_000,
    parameter int unsigned ROLL_STEPS  = 20,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_n,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic                    rolling,
    output logic                    valid
);

    localparam int unsigned CW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned SW        = $clog2(ROLL_STEPS + 1);
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] POLY      = 16'hB400;
    localparam logic [CW-1:0] CYC_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(ROLL_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        HOLD
    } state_t;

    state_t                  state_q;
    logic                    s1_q, s2_q, s2d_q;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [3:0]              cand_q, cand_d;
    logic [CW-1:0]           cyc_q;
    logic [SW-1:0]           step_q;
    logic [4*NUM_DIGITS-1:0] digits_q, shifted_d;
    logic                    rolling_q, valid_q;
    logic                    press;

    assign press = s2d_q & ~s2_q;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? POLY : 16'h0000);
        // Rejection sampling: nibbles 10-15 are skipped so every digit is equally likely.
        cand_d = (lfsr_q[3:0] <= 4'd9) ? lfsr_q[3:0] : cand_q;
        shifted_d = '0;
        shifted_d[3:0] = cand_q;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            shifted_d[4*k +: 4] = digits_q[4*(k-1) +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s2d_q     <= 1'b1;
            lfsr_q    <= SEED_EFF;
            cand_q    <= '0;
            state_q   <= IDLE;
            cyc_q     <= '0;
            step_q    <= '0;
            digits_q  <= '0;
            rolling_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            s1_q   <= btn_n;
            s2_q   <= s1_q;
            s2d_q  <= s2_q;
            lfsr_q <= lfsr_d;
            cand_q <= cand_d;
            case (state_q)
                IDLE, HOLD: begin
                    if (press) begin
                        state_q   <= ROLL;
                        rolling_q <= 1'b1;
                        valid_q   <= 1'b0;
                        cyc_q     <= '0;
                        step_q    <= '0;
                    end
                end
                ROLL: begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_q    <= '0;
                        digits_q <= shifted_d;
                        step_q   <= step_q + SW'(1);
                        if (step_q == STEP_LAST) begin
                            state_q   <= HOLD;
                            rolling_q <= 1'b0;
                            valid_q   <= 1'b1;
                        end
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rolling_q <= 1'b0;
                    valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign digits_out = digits_q;
    assign rolling    = rolling_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_random_digit_gen.sv
// Scoreboard bench for random_digit_gen: a behavioural model predicts each roll
// result; a monitor checks it when valid rises, plus per-cycle output checks.
module tb_random_digit_gen;

    localparam int unsigned ND   = 2;
    localparam int unsigned SC   = 4;
    localparam int unsigned RS   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_n = 1'b1;
    logic [4*ND-1:0] digits_out;
    logic rolling, valid;

    random_digit_gen #(
        .NUM_DIGITS (ND),
        .STEP_CYCLES(SC),
        .ROLL_STEPS (RS),
        .SEED       (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .digits_out(digits_out),
        .rolling   (rolling),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct {
        logic [4*ND-1:0] d;
        int unsigned     cyc;
    } res_t;
    res_t sbq[$];

    // Behavioural reference state
    logic [15:0] m_lfsr = SEED;
    logic [3:0]  m_cand = '0;
    int          m_dig[ND];
    bit          m_rolling = 0;
    bit          m_holding = 0;
    int unsigned m_elapsed = 0;
    logic [2:0]  m_hist = 3'b111;
    int unsigned cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [4*ND-1:0] model_digits();
        logic [4*ND-1:0] p;
        p = '0;
        for (int k = 0; k < ND; k++) p[4*k +: 4] = m_dig[k][3:0];
        return p;
    endfunction

    task automatic model_edge();
        logic [15:0] lf;
        bit press;
        cyc++;
        if (rst) begin
            m_lfsr = SEED;
            m_cand = '0;
            for (int k = 0; k < ND; k++) m_dig[k] = 0;
            m_rolling = 0;
            m_holding = 0;
            m_elapsed = 0;
            m_hist = 3'b111;
        end else begin
            lf = m_lfsr;
            press = m_hist[2] && !m_hist[1];
            if (m_rolling) begin
                m_elapsed++;
                if (m_elapsed % SC == 0) begin
                    for (int k = ND - 1; k > 0; k--) m_dig[k] = m_dig[k-1];
                    m_dig[0] = int'(m_cand);
                end
                if (m_elapsed == SC * RS) begin
                    m_rolling = 0;
                    m_holding = 1;
                    sbq.push_back('{model_digits(), cyc});
                end
            end else if (press) begin
                m_rolling = 1;
                m_holding = 0;
                m_elapsed = 0;
            end
            if (lf[3:0] <= 4'd9) m_cand = lf[3:0];
            m_lfsr = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
            m_hist = {m_hist[1:0], btn_n};
        end
    endtask

    initial begin
        for (int k = 0; k < ND; k++) m_dig[k] = 0;
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // Per-cycle checks plus scoreboard pop on each valid rise
    initial begin
        logic prev_valid;
        res_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            check("rolling", 32'(rolling), 32'(m_rolling));
            check("valid", 32'(valid), 32'(m_holding));
            check("exclusive", 32'(rolling && valid), 32'd0);
            check("digits", 32'(digits_out), 32'(model_digits()));
            check("lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
            check("cand", 32'(dut.cand_q), 32'(m_cand));
            for (int k = 0; k < ND; k++)
                check("field_le9", 32'(digits_out[4*k +: 4] <= 4'd9), 32'd1);
            if (valid === 1'b1 && prev_valid !== 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("result", 32'(digits_out), 32'(e.d));
                    check("result_cycle", cyc, e.cyc);
                end
            end
            prev_valid = valid;
        end
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int unsigned low_len);
        btn_n = 1'b0;
        wait_cycles(low_len);
        btn_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        btn_n = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(20);

        // Long hold produces a single roll
        pulse(50);
        wait_cycles(10);

        // Second pulse during the roll must not extend it
        pulse(2);
        wait_cycles(7);
        pulse(10);
        wait_cycles(10);

        // Re-press from HOLD
        pulse(4);
        wait_cycles(20);

        // Reset in the middle of a roll, then a normal roll
        pulse(3);
        wait_cycles(7);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(5);
        pulse(3);
        wait_cycles(20);

        for (int i = 0; i < 1200; i++) begin
            wait_cycles($urandom_range(0, 15));
            pulse($urandom_range(1, 20));
            if ($urandom_range(0, 39) == 0) begin
                wait_cycles($urandom_range(0, 14));
                rst = 1'b1;
                wait_cycles(1);
                rst = 1'b0;
            end
        end

        wait_cycles(40);
        check("pending_results", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
